led_btn_ctrl: RTL and testbench
===============================

LED_BTN_CTRL -- requirements
Module: led_btn_ctrl

Interface
REQ-001 SHALL have parameter NBTN, default 4, number of button inputs (1..32).
REQ-002 SHALL have parameter NLED, default 8, number of LED outputs (1..32).
REQ-003 SHALL have parameter DB_CYCLES, default 1000000, debounce stable-sample count (>=2).
REQ-004 SHALL have parameter PWM_BITS, default 8, PWM counter width (2..16).
REQ-005 SHALL have parameter BLINK_DIV, default 50000000, clock cycles per blink half-period (>=1).
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port btn, input, NBTN, raw asynchronous button levels.
REQ-009 SHALL have port btn_db, output, NBTN, debounced button levels.
REQ-010 SHALL have port btn_rise, output, NBTN, one-cycle pulse on debounced 0->1.
REQ-011 SHALL have port btn_fall, output, NBTN, one-cycle pulse on debounced 1->0.
REQ-012 SHALL have port led_mode, input, 2*NLED, per-LED mode; bits [2i+1:2i] belong to LED i.
REQ-013 SHALL have port led_val, input, NLED, per-LED level used in DIRECT mode.
REQ-014 SHALL have port led_duty, input, PWM_BITS*NLED, per-LED duty; slice i at [PWM_BITS*(i+1)-1:PWM_BITS*i].
REQ-015 SHALL have port led, output, NLED, registered LED drive.

Function
REQ-016 SHALL pass each btn bit through a 2-flop synchroniser before any other use.
REQ-017 SHALL keep one debounce counter per button: cleared when synced sample equals btn_db, incremented when it differs.
REQ-018 SHALL update btn_db to the synced sample and clear the counter in the cycle the counter reaches DB_CYCLES-1, i.e. after DB_CYCLES consecutive differing samples.
REQ-019 SHALL restart the count from zero on any intermediate sample equal to btn_db (a bounce); no partial credit is retained.
REQ-020 SHALL assert btn_rise/btn_fall in the same cycle btn_db changes, for exactly one cycle; never both for one button in one cycle.
REQ-021 SHALL give total latency btn edge -> btn_db change of DB_CYCLES+2 cycles for a clean edge.
REQ-022 SHALL run one shared free-running PWM counter of PWM_BITS, wrapping from 2^PWM_BITS-1 to 0.
REQ-023 SHALL run one shared blink prescaler toggling a blink phase bit every BLINK_DIV cycles; the phase starts at 0.
REQ-024 SHALL decode mode 00 DIRECT: led[i] = led_val[i].
REQ-025 SHALL decode mode 01 PWM: led[i] = 1 when the PWM counter < duty_i; duty 0 gives constant off; duty 2^PWM_BITS-1 gives on for all but one count per period.
REQ-026 SHALL decode mode 10 BLINK: led[i] = blink phase.
REQ-027 SHALL decode mode 11 OFF: led[i] = 0.
REQ-028 SHALL register led with one cycle latency from led_mode/led_val/led_duty and the counters; mode changes take effect on the next edge without resetting shared counters.
REQ-029 SHALL make each LED independent: any mix of modes across LEDs is legal.

Reset
REQ-030 SHALL, while reset is high, clear synchronisers, debounce counters, btn_db, btn_rise, btn_fall, the PWM counter, the blink prescaler and phase, and led to 0.
REQ-031 SHALL discard any in-progress debounce count when reset is asserted mid-count; a held button re-qualifies DB_CYCLES+2 cycles after reset release.
REQ-032 SHALL produce no btn_rise/btn_fall pulse in the cycle reset deasserts.

Structure
REQ-033 SHALL define in package led_btn_pkg: enum led_mode_t {LED_DIRECT=2'b00, LED_PWM=2'b01, LED_BLINK=2'b10, LED_OFF=2'b11}.
REQ-034 SHALL instantiate one sub-module btn_debounce (sync, counter, edge pulses) per button via generate.
REQ-035 SHALL stop elaboration via parameter checks when DB_CYCLES<2 or PWM_BITS is outside 2..16.

Verification (NBTN=2, NLED=4, DB_CYCLES=4, PWM_BITS=4, BLINK_DIV=5)
REQ-036 SHALL cover: btn[0] 0->1 held -> btn_db[0]=1 and btn_rise[0] single pulse 6 cycles after edge.
REQ-037 SHALL cover: btn[0] high 3 cycles, low 1, high 4 -> no qualification until 4 consecutive highs; one btn_rise only.
REQ-038 SHALL cover: LED0 PWM duty 5 -> led[0] high exactly 5 of every 16 cycles; duty 0 -> always 0; duty 15 -> high 15 of 16.
REQ-039 SHALL cover: LED1 BLINK -> led[1] toggles every 5 cycles, first high 6 cycles after reset release.
REQ-040 SHALL cover: LED2 DIRECT led_val=1 then mode switched to OFF -> led[2] falls 1 cycle after the mode change.
REQ-041 SHALL cover: reset asserted at debounce count 2 while btn held -> all outputs 0; btn_db rises 6 cycles after release; no edge pulse at release.

Source files
------------

// File: rtl/led_btn_pkg.sv
// Shared types and helpers for the LED / button controller.
// The LED mode encoding is also what software writes into led_mode.
package led_btn_pkg;

   typedef enum logic [1:0] {
      LED_DIRECT = 2'b00,
      LED_PWM    = 2'b01,
      LED_BLINK  = 2'b10,
      LED_OFF    = 2'b11
   } led_mode_t;

   // Counter width able to hold 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic led_drive(input led_mode_t mode,
                                      input logic      val,
                                      input logic      pwm_on,
                                      input logic      phase);
      logic drv;
      case (mode)
         LED_DIRECT: drv = val;
         LED_PWM:    drv = pwm_on;
         LED_BLINK:  drv = phase;
         default:    drv = 1'b0;
      endcase
      return drv;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stable-sample debounce counter, edge pulses.
// Any sample matching the current debounced level restarts the count.
module btn_debounce
   import led_btn_pkg::*;
#(
   parameter int DB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic db_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int            CW       = cnt_width(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          db_q, db_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d  = cnt_q;
      db_d   = db_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (sync2_q == db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d  = '0;
         db_d   = sync2_q;
         rise_d = sync2_q;
         fall_d = ~sync2_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         db_q    <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         db_q    <= db_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign db_o   = db_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/led_btn_ctrl.sv
// Debounced button inputs plus per-LED drive (direct / PWM / blink / off)
// sharing one PWM counter and one blink prescaler.
module led_btn_ctrl
   import led_btn_pkg::*;
#(
   parameter int NBTN      = 4,
   parameter int NLED      = 8,
   parameter int DB_CYCLES = 1000000,
   parameter int PWM_BITS  = 8,
   parameter int BLINK_DIV = 50000000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NBTN-1:0]          btn,
   output logic [NBTN-1:0]          btn_db,
   output logic [NBTN-1:0]          btn_rise,
   output logic [NBTN-1:0]          btn_fall,
   input  logic [2*NLED-1:0]        led_mode,
   input  logic [NLED-1:0]          led_val,
   input  logic [PWM_BITS*NLED-1:0] led_duty,
   output logic [NLED-1:0]          led
);

   generate
      if (DB_CYCLES < 2) begin : g_bad_db
         $error("led_btn_ctrl: DB_CYCLES must be >= 2");
      end
      if (PWM_BITS < 2 || PWM_BITS > 16) begin : g_bad_pwm
         $error("led_btn_ctrl: PWM_BITS must be in 2..16");
      end
      if (NBTN < 1 || NBTN > 32 || NLED < 1 || NLED > 32) begin : g_bad_cnt
         $error("led_btn_ctrl: NBTN and NLED must be in 1..32");
      end
      if (BLINK_DIV < 1) begin : g_bad_blink
         $error("led_btn_ctrl: BLINK_DIV must be >= 1");
      end
   endgenerate

   genvar g;
   generate
      for (g = 0; g < NBTN; g++) begin : g_btn
         btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .btn_i  (btn[g]),
            .db_o   (btn_db[g]),
            .rise_o (btn_rise[g]),
            .fall_o (btn_fall[g])
         );
      end
   endgenerate

   localparam int            BW         = cnt_width(BLINK_DIV);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [PWM_BITS-1:0] pwm_q;
   logic [BW-1:0]       presc_q, presc_d;
   logic                phase_q, phase_d;
   logic [NLED-1:0]     led_q, led_d;

   always_comb begin
      presc_d = presc_q + 1'b1;
      phase_d = phase_q;
      if (presc_q == BLINK_LAST) begin
         presc_d = '0;
         phase_d = ~phase_q;
      end
   end

   // LED outputs see the counter values from before this edge.
   always_comb begin
      led_d = '0;
      for (int i = 0; i < NLED; i++) begin
         led_d[i] = led_drive(led_mode_t'(led_mode[2*i +: 2]),
                              led_val[i],
                              pwm_q < led_duty[PWM_BITS*i +: PWM_BITS],
                              phase_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_q   <= '0;
         presc_q <= '0;
         phase_q <= 1'b0;
         led_q   <= '0;
      end else begin
         pwm_q   <= pwm_q + 1'b1;
         presc_q <= presc_d;
         phase_q <= phase_d;
         led_q   <= led_d;
      end
   end

   assign led = led_q;

endmodule

// File: tb/tb_led_btn_ctrl.sv
// Bench for led_btn_ctrl: cycle model compared every cycle plus directed
// latency / count checks for buttons, PWM, blink, mode change and reset.
module tb_led_btn_ctrl;

   localparam int NBTN = 2;
   localparam int NLED = 4;
   localparam int DB   = 4;
   localparam int PB   = 4;
   localparam int BDIV = 5;

   logic                clk = 1'b0;
   logic                reset;
   logic [NBTN-1:0]     btn;
   logic [NBTN-1:0]     btn_db, btn_rise, btn_fall;
   logic [2*NLED-1:0]   led_mode;
   logic [NLED-1:0]     led_val;
   logic [PB*NLED-1:0]  led_duty;
   logic [NLED-1:0]     led;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   led_btn_ctrl #(
      .NBTN(NBTN), .NLED(NLED), .DB_CYCLES(DB), .PWM_BITS(PB), .BLINK_DIV(BDIV)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .btn      (btn),
      .btn_db   (btn_db),
      .btn_rise (btn_rise),
      .btn_fall (btn_fall),
      .led_mode (led_mode),
      .led_val  (led_val),
      .led_duty (led_duty),
      .led      (led)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // t = clean edges since reset; PWM count before edge = t mod 2^PB,
   // blink phase before edge = (t / BDIV) odd. Buttons: raw level seen two
   // edges late, level flips after DB consecutive differing samples.
   int              t;
   logic [NBTN-1:0] m_b1, m_b2, m_db, m_rise, m_fall;
   int              streak [NBTN];
   logic [NLED-1:0] m_led;

   always @(posedge clk) begin
      if (reset) begin
         t = 0;
         m_b1 = '0; m_b2 = '0; m_db = '0; m_rise = '0; m_fall = '0; m_led = '0;
         for (int b = 0; b < NBTN; b++) streak[b] = 0;
      end else begin
         for (int i = 0; i < NLED; i++) begin
            logic [1:0] md;
            int         duty;
            md   = led_mode[2*i +: 2];
            duty = int'(led_duty[PB*i +: PB]);
            case (md)
               2'b00:   m_led[i] = led_val[i];
               2'b01:   m_led[i] = ((t % (1 << PB)) < duty);
               2'b10:   m_led[i] = (((t / BDIV) % 2) == 1);
               default: m_led[i] = 1'b0;
            endcase
         end
         t++;
         for (int b = 0; b < NBTN; b++) begin
            logic s;
            s = m_b2[b];
            m_rise[b] = 1'b0;
            m_fall[b] = 1'b0;
            if (s != m_db[b]) begin
               streak[b]++;
               if (streak[b] == DB) begin
                  m_db[b]   = s;
                  m_rise[b] = s;
                  m_fall[b] = ~s;
                  streak[b] = 0;
               end
            end else begin
               streak[b] = 0;
            end
         end
         m_b2 = m_b1;
         m_b1 = btn;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         n_tests++;
         if ({btn_db, btn_rise, btn_fall, led} !== {m_db, m_rise, m_fall, m_led}) begin
            n_fail++;
            $display("FAIL model_cmp @%0t got db=%b rise=%b fall=%b led=%b expected db=%b rise=%b fall=%b led=%b",
                     $time, btn_db, btn_rise, btn_fall, led, m_db, m_rise, m_fall, m_led);
         end
      end
   end

   // ---------------- driver / directed checks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   int first_k, pwm_hi, rise_cnt, fall_cnt;
   logic [23:0] pat1;

   initial begin
      reset    = 1'b1;
      btn      = '0;
      led_mode = {2'b11, 2'b00, 2'b10, 2'b01};   // LED3 OFF, LED2 DIRECT, LED1 BLINK, LED0 PWM
      led_val  = 4'b0100;
      led_duty = 16'h0005;
      tick();
      chk_en = 1'b1;
      tick();
      tick();
      check("reset_outputs", {20'd0, btn_db, btn_rise, btn_fall, led}, 32'd0);

      // Blink / PWM / direct after reset release
      reset   = 1'b0;
      first_k = 0;
      pwm_hi  = 0;
      for (int k = 1; k <= 32; k++) begin
         tick();
         if (led[1] && first_k == 0) first_k = k;
         if (k <= 16) pwm_hi += int'(led[0]);
         if (k == 1)  check("direct_on", {31'd0, led[2]}, 32'd1);
         if (k == 11) check("blink_low_k11", {31'd0, led[1]}, 32'd0);
         if (k == 16) check("blink_high_k16", {31'd0, led[1]}, 32'd1);
      end
      check("blink_first_high", first_k, 6);
      check("pwm_duty5_highs", pwm_hi, 5);

      // DIRECT -> OFF on LED2
      led_mode[5:4] = 2'b11;
      check("off_not_yet", {31'd0, led[2]}, 32'd1);
      tick();
      check("off_after_1", {31'd0, led[2]}, 32'd0);

      // PWM extremes
      led_duty[3:0] = 4'd0;
      pwm_hi = 0;
      for (int k = 1; k <= 16; k++) begin tick(); pwm_hi += int'(led[0]); end
      check("pwm_duty0_highs", pwm_hi, 0);
      led_duty[3:0] = 4'd15;
      pwm_hi = 0;
      for (int k = 1; k <= 16; k++) begin tick(); pwm_hi += int'(led[0]); end
      check("pwm_duty15_highs", pwm_hi, 15);

      // Clean press then release on btn[0]
      btn[0]   = 1'b1;
      first_k  = 0;
      rise_cnt = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         rise_cnt += int'(btn_rise[0]);
         if (btn_db[0] && first_k == 0) begin
            first_k = k;
            check("rise_with_db", {31'd0, btn_rise[0]}, 32'd1);
         end
      end
      check("press_latency", first_k, 6);
      check("press_rise_count", rise_cnt, 1);
      btn[0]   = 1'b0;
      first_k  = 0;
      fall_cnt = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         fall_cnt += int'(btn_fall[0]);
         if (!btn_db[0] && first_k == 0) first_k = k;
      end
      check("release_latency", first_k, 6);
      check("release_fall_count", fall_cnt, 1);

      // Bounce on btn[0] (3 high, 1 low, then held high); pattern on btn[1]
      pat1     = 24'b0000_0000_0111_1101_1101_0110;
      first_k  = 0;
      rise_cnt = 0;
      for (int k = 1; k <= 24; k++) begin
         btn[0] = (k == 4) ? 1'b0 : 1'b1;
         btn[1] = pat1[k-1];
         tick();
         rise_cnt += int'(btn_rise[0]);
         if (btn_db[0] && first_k == 0) first_k = k;
      end
      check("bounce_latency", first_k, 10);
      check("bounce_rise_count", rise_cnt, 1);
      btn = '0;
      repeat (10) tick();

      // Reset mid-count while btn[0] held
      btn[0] = 1'b1;
      repeat (4) tick();
      reset = 1'b1;
      tick();
      tick();
      check("midcount_reset_outputs", {20'd0, btn_db, btn_rise, btn_fall, led}, 32'd0);
      reset    = 1'b0;
      first_k  = 0;
      rise_cnt = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 1) check("no_pulse_at_release", {30'd0, btn_rise | btn_fall}, 32'd0);
         rise_cnt += int'(btn_rise[0]);
         if (btn_db[0] && first_k == 0) first_k = k;
      end
      check("requalify_latency", first_k, 6);
      check("requalify_rise_count", rise_cnt, 1);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
